// File: rtl/pl_pkg.sv
// Shared PLCPU pipeline definitions: data width, bubble encoding,
// fetch-stage state encoding and the IF/ID record type.
package pl_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

    // Empty pipeline slot: no PC, bubble instruction, not valid.
    function automatic if_id_t bubble_rec(input logic [XLEN-1:0] nop = NOP_INSTR);
        if_id_t r;
        r.pc    = '0;
        r.instr = nop;
        r.valid = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Bus bundle between the fetch stage and its surroundings: instruction
// memory, downstream control (stall/flush/redirect) and the IF/ID outputs.
interface if_fetch_stage_if;
    import pl_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            stall;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_instr;
    logic            id_valid;
    logic            halted;
    logic [XLEN-1:0] fetch_count;

    // Environment side: memory, hazard unit, EX stage, decode.
    modport master (
        input  imem_addr,
        output imem_rdata,
        output stall,
        output flush,
        output redirect_valid,
        output redirect_pc,
        input  id_pc,
        input  id_instr,
        input  id_valid,
        input  halted,
        input  fetch_count
    );

    // Fetch stage side.
    modport slave (
        output imem_addr,
        input  imem_rdata,
        input  stall,
        input  flush,
        input  redirect_valid,
        input  redirect_pc,
        output id_pc,
        output id_instr,
        output id_valid,
        output halted,
        output fetch_count
    );

endinterface

// File: rtl/if_id_reg.sv
// Generic pipeline register: hold on hold_i, load a bubble on bubble_i
// (bubble wins over hold), otherwise capture d_i. Synchronous active-low reset.
module if_id_reg
    import pl_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_VAL = pl_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   hold_i,
    input  logic   bubble_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t q_q;
    if_id_t q_d;

    // Select bubble, hold or new contents.
    always_comb begin
        q_d = q_q;
        if (bubble_i) begin
            q_d = bubble_rec(NOP_VAL);
        end else if (!hold_i) begin
            q_d = d_i;
        end
    end

    // Register with synchronous reset to an empty slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= bubble_rec(NOP_VAL);
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/if_fetch_stage.sv
// PLCPU instruction-fetch stage: owns the PC, reads instruction memory,
// fills IF/ID and stops fetching once the PC runs past the program image.
//
//   state  | meaning
//   RUN    | fetching normally; moves to HALTED when pc passes the last address
//   HALTED | no fetch, IF/ID filled with bubbles; left only by an in-range redirect
module if_fetch_stage
    import pl_pkg::*;
#(
    parameter int unsigned     IMEM_DEPTH     = 1024,
    parameter logic [XLEN-1:0] MAX_INSTR_ADDR = 32'h0000_00a0,
    parameter logic [XLEN-1:0] RESET_PC       = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR      = pl_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    if_fetch_stage_if.slave    bus
);

    if (MAX_INSTR_ADDR >= 4 * IMEM_DEPTH) begin : g_bad_max_addr
        $error("if_fetch_stage: MAX_INSTR_ADDR must lie inside instruction memory");
    end

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] cnt_q;
    logic [XLEN-1:0] cnt_d;

    logic [XLEN-1:0] redir_tgt;
    logic            ifid_hold;
    logic            ifid_bubble;
    logic            load_valid;
    if_id_t          ifid_d;
    if_id_t          ifid_q;

    // Low two bits are masked rather than sliced so the whole bus is consumed.
    assign redir_tgt = bus.redirect_pc & ~32'h3;

    // Next PC, next state and IF/ID control, in priority redirect > stall > halt > flush > fetch.
    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        ifid_hold   = 1'b0;
        ifid_bubble = 1'b0;
        load_valid  = 1'b0;
        if (bus.redirect_valid) begin
            pc_d        = redir_tgt;
            ifid_bubble = 1'b1;
            state_d     = (redir_tgt > MAX_INSTR_ADDR) ? HALTED : RUN;
        end else if (bus.stall) begin
            ifid_hold   = 1'b1;
            ifid_bubble = bus.flush;
            if (pc_q > MAX_INSTR_ADDR) begin
                state_d = HALTED;
            end
        end else if ((state_q == HALTED) || (pc_q > MAX_INSTR_ADDR)) begin
            ifid_bubble = 1'b1;
            state_d     = HALTED;
        end else if (bus.flush) begin
            ifid_bubble = 1'b1;
            pc_d        = pc_q + 32'd4;
        end else begin
            load_valid  = 1'b1;
            pc_d        = pc_q + 32'd4;
        end
    end

    // Delivered-instruction counter, saturating at all ones.
    always_comb begin
        cnt_d = cnt_q;
        if (load_valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // PC, fetch state and counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ifid_d = '{pc: pc_q, instr: bus.imem_rdata, valid: 1'b1};

    if_id_reg #(
        .NOP_VAL (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .hold_i   (ifid_hold),
        .bubble_i (ifid_bubble),
        .d_i      (ifid_d),
        .q_o      (ifid_q)
    );

    assign bus.imem_addr   = pc_q & ~32'h3;
    assign bus.id_pc       = ifid_q.pc;
    assign bus.id_instr    = ifid_q.instr;
    assign bus.id_valid    = ifid_q.valid;
    assign bus.halted      = (state_q == HALTED);
    assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a queue-based scoreboard.
module tb_if_fetch_stage;
    import pl_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        int          step;
        logic [31:0] addr;
        logic [31:0] id_pc;
        logic [31:0] instr;
        logic        valid;
        logic        halted;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    logic [31:0] imem [1024];
    exp_t sb [$];
    int checks;
    int errors;
    int step_no;

    if_fetch_stage_if bus ();

    if_fetch_stage #(
        .IMEM_DEPTH     (1024),
        .MAX_INSTR_ADDR (32'h0000_00a0),
        .RESET_PC       (32'h0),
        .NOP_INSTR      (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.imem_rdata = imem[bus.imem_addr[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            32'hc:   return 32'h44;
            default: return 32'ha000_0000 | (a >> 2);
        endcase
    endfunction

    function automatic void chk(input string name, input int stp,
                                input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step %0d %s: got %h expected %h", stp, name, got, want);
        end
    endfunction

    // Monitor: outputs are stable away from the rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("imem_addr",   e.step, bus.imem_addr,   e.addr);
            chk("id_pc",       e.step, bus.id_pc,       e.id_pc);
            chk("id_instr",    e.step, bus.id_instr,    e.instr);
            chk("id_valid",    e.step, {31'b0, bus.id_valid}, {31'b0, e.valid});
            chk("halted",      e.step, {31'b0, bus.halted},   {31'b0, e.halted});
            chk("fetch_count", e.step, bus.fetch_count, e.cnt);
        end
    end

    task automatic step(input logic r, input logic s, input logic f,
                        input logic rv, input logic [31:0] rpc,
                        input logic [31:0] ea, input logic [31:0] eidpc,
                        input logic [31:0] ein, input logic ev,
                        input logic eh, input logic [31:0] ec);
        exp_t e;
        rst                = r;
        bus.stall          = s;
        bus.flush          = f;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        @(posedge clk);
        #1;
        step_no++;
        e.step = step_no; e.addr = ea; e.id_pc = eidpc; e.instr = ein;
        e.valid = ev; e.halted = eh; e.cnt = ec;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c;
        checks  = 0;
        errors  = 0;
        step_no = 0;
        for (int i = 0; i < 1024; i++) imem[i] = 32'ha000_0000 | i;
        imem[0] = 32'h11; imem[1] = 32'h22; imem[2] = 32'h33; imem[3] = 32'h44;

        // reset
        step(0,0,0,0,0,  32'h0, 32'h0, NOP, 0, 0, 0);
        step(0,0,0,0,0,  32'h0, 32'h0, NOP, 0, 0, 0);
        // free run over the first words
        step(1,0,0,0,0,  32'h4, 32'h0, 32'h11, 1, 0, 1);
        step(1,0,0,0,0,  32'h8, 32'h4, 32'h22, 1, 0, 2);
        // stall two cycles at pc=8
        step(1,1,0,0,0,  32'h8, 32'h4, 32'h22, 1, 0, 2);
        step(1,1,0,0,0,  32'h8, 32'h4, 32'h22, 1, 0, 2);
        step(1,0,0,0,0,  32'hc, 32'h8, 32'h33, 1, 0, 3);
        step(1,0,0,0,0,  32'h10, 32'hc, 32'h44, 1, 0, 4);
        // redirect to unaligned 0x43 together with stall
        step(1,1,0,1,32'h43, 32'h40, 32'h0, NOP, 0, 0, 4);
        step(1,0,0,0,0,  32'h44, 32'h40, 32'ha000_0010, 1, 0, 5);
        // flush alone, then stall+flush
        step(1,0,1,0,0,  32'h48, 32'h0, NOP, 0, 0, 5);
        step(1,1,1,0,0,  32'h48, 32'h0, NOP, 0, 0, 5);
        // run to the end of the image
        c = 5;
        for (logic [31:0] a = 32'h48; a <= 32'ha0; a += 4) begin
            c++;
            step(1,0,0,0,0, a + 32'd4, a, word_at(a), 1, 0, c);
        end
        step(1,0,0,0,0,  32'ha4, 32'h0, NOP, 0, 1, 28);
        step(1,0,0,0,0,  32'ha4, 32'h0, NOP, 0, 1, 28);
        step(1,0,0,0,0,  32'ha4, 32'h0, NOP, 0, 1, 28);
        // out-of-range redirect keeps halted, in-range redirect resumes
        step(1,0,0,1,32'hc0, 32'hc0, 32'h0, NOP, 0, 1, 28);
        step(1,0,0,0,0,  32'hc0, 32'h0, NOP, 0, 1, 28);
        step(1,0,0,1,32'h10, 32'h10, 32'h0, NOP, 0, 0, 28);
        step(1,0,0,0,0,  32'h14, 32'h10, 32'ha000_0004, 1, 0, 29);
        step(1,0,0,0,0,  32'h18, 32'h14, 32'ha000_0005, 1, 0, 30);
        // reset mid-run beats stall, flush and redirect
        step(0,1,1,1,32'h80, 32'h0, 32'h0, NOP, 0, 0, 0);
        step(1,0,0,0,0,  32'h4, 32'h0, 32'h11, 1, 0, 1);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the PLCPU pipeline. Sits between the PC logic and the decode stage.
- Owns the PC, drives the instruction-memory read address and captures the returned word into the IF/ID pipeline register.
- Applies stall, flush and branch/jump redirects from downstream stages.
- Halts fetch cleanly once the PC passes the last valid instruction address, so programs loaded from .dat images terminate without fetching garbage.

Parameters:
- IMEM_DEPTH, 1024, instruction memory size in 32-bit words.
- MAX_INSTR_ADDR, 32'ha0, byte address of the last valid instruction; elaboration error unless MAX_INSTR_ADDR < 4*IMEM_DEPTH.
- RESET_PC, 32'h0, PC value after reset.
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low.
- imem_addr  out  32  word-aligned byte address to instruction memory; equals {pc[31:2],2'b00}.
- imem_rdata  in  32  instruction word; combinational read of imem_addr, valid in the same cycle.
- stall  in  1  hazard unit: hold PC and IF/ID contents.
- flush  in  1  load a bubble into IF/ID.
- redirect_valid  in  1  taken branch or jump from EX.
- redirect_pc  in  32  redirect target.
- id_pc  out  32  PC of the instruction in IF/ID.
- id_instr  out  32  instruction in IF/ID.
- id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch is stopped: PC > MAX_INSTR_ADDR.
- fetch_count  out  32  number of instructions delivered to IF/ID; saturating.

Behaviour:
- Reset (rst==0 at a rising edge):
  - pc=RESET_PC, id_pc=0, id_instr=NOP_INSTR, id_valid=0, halted=0, fetch_count=0, state=RUN.
  - Reset mid-operation discards any pending redirect or stall that cycle.
- Latency: the word at pc appears on id_instr/id_pc one cycle later, provided no stall, flush or redirect occurs.
- Redirect alignment: redirect_pc[1:0] is forced to 0.
- Priority per cycle: reset > redirect > stall > normal.
  - Redirect: pc <= aligned redirect_pc. IF/ID loads a bubble (id_valid=0, id_instr=NOP_INSTR). The redirect wins even when stall is also high.
  - Stall without redirect: pc holds. IF/ID holds, unless flush is high, in which case IF/ID becomes a bubble.
  - Flush without redirect or stall: IF/ID becomes a bubble and pc <= pc+4.
  - Normal: IF/ID <= {pc, imem_rdata, valid=1}; pc <= pc+4 (wraps modulo 2^32).
- State machine (2 states):
  - RUN:
    - If pc > MAX_INSTR_ADDR, no fetch occurs: IF/ID loads a bubble, pc holds and the state goes to HALTED.
    - A redirect in the same cycle takes precedence and is evaluated against its target instead.
  - HALTED:
    - halted=1; IF/ID loads a bubble every cycle (unless stalled); pc holds.
    - Exit only via redirect with target <= MAX_INSTR_ADDR, which sets pc and returns to RUN.
    - A redirect with target > MAX_INSTR_ADDR updates pc and stays in HALTED.
  - halted is a registered output that equals (state==HALTED).
- fetch_count increments exactly when IF/ID is loaded with id_valid=1. It saturates at 32'hFFFFFFFF and holds during stall.
- imem_addr is always driven, including in HALTED; instruction memory reads have no side effects.

Decomposition:
- Shared package pl_pkg:
  - NOP_INSTR constant.
  - Fetch state enum: RUN=1'b0, HALTED=1'b1.
  - XLEN=32.
  - Bubble-record helper: pc=0, instr=NOP, valid=0.
- One natural sub-module: if_id_reg. It is the IF/ID register with hold (stall), bubble-load (flush) and synchronous active-low reset, reusable for the other pipeline registers.
- PC/next-PC logic and the FSM stay in if_fetch_stage.

Test Plan:
- Reset then free-run with imem[0..3]=11,22,33,44 -> cycles 1-4 after reset release show id_pc=0,4,8,12, id_instr=11,22,33,44, id_valid=1, fetch_count=4.
- stall high for 2 cycles while pc=8 -> id_pc stays 4 and pc stays 8 for 2 cycles; then id_pc=8; fetch_count does not increment during the stall.
- redirect_valid with redirect_pc=32'h43 and stall both high at pc=16 -> next cycle pc=32'h40, id_valid=0, id_instr=NOP; the following cycle id_pc=32'h40.
- Run straight to the end with MAX_INSTR_ADDR=32'ha0 -> last valid id_pc=32'ha0; the cycle after pc=32'ha4, halted=1, id_valid=0 and pc holds at 32'ha4 indefinitely.
- While halted, redirect_pc=32'hc0 -> stays halted with pc=32'hc0; then redirect_pc=32'h10 -> halted=0 and id_pc=32'h10 one cycle later.
- rst driven low mid-run with stall and flush high -> the next edge gives pc=0, id_valid=0, fetch_count=0, halted=0.
